// File: rtl/bz_rx_arb_pkg.sv
// Shared definitions for the router-to-core receive arbiter: flit format
// constants, the flit type, the arbiter state encoding and a tail helper.
package bz_rx_arb_pkg;

    localparam int FLIT_W   = 11;
    localparam int TAIL_BIT = 10;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // True when the flit carries the end-of-packet marker
    function automatic logic is_tail(input flit_t f);
        return f[TAIL_BIT];
    endfunction

endpackage

// File: rtl/bz_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// when searching cyclically upward starting at ptr+1, so the index at ptr
// itself has the lowest priority. Kept generic so other arbiters can use it.
module bz_rr_pick #(
    parameter int NIN   = 4,
    parameter int IDX_W = $clog2(NIN)
) (
    input  logic [NIN-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk from the farthest candidate to the nearest so the nearest match wins
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NIN; k >= 1; k--) begin
            cand = (int'(ptr) + k) % NIN;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bz_rx_arbiter.sv
// Packet-level round-robin arbiter sharing one deserializer between NIN
// show-ahead flit FIFOs. It looks like a single FIFO to the deserializer and
// stays locked on one port from a header flit to the tail-marked data flit.
// Optional statistics counters are enabled with the BZ_RX_ARB_STATS_EN macro.
module bz_rx_arbiter
    import bz_rx_arb_pkg::*;
#(
    parameter int NIN       = 4,
    parameter int MAX_FLITS = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NIN-1:0]        in_isempty,
    input  logic [NIN*FLIT_W-1:0] in_data,
    output logic [NIN-1:0]        in_rdreq,
    output logic                  out_isempty,
    output logic [FLIT_W-1:0]     out_data,
    input  logic                  out_rdreq,
    output logic [NIN-1:0]        grant,
    output logic                  err_overlong
`ifdef BZ_RX_ARB_STATS_EN
    ,
    output logic [NIN*16-1:0]     pkt_count,
    output logic [7:0]            overlong_count
`endif
);

    localparam int IDX_W = $clog2(NIN);
    localparam int CNT_W = $clog2(MAX_FLITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_FLITS - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [CNT_W-1:0] flit_cnt;

    logic [NIN-1:0]   req_vec;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    flit_t            sel_flit;
    logic             sel_empty;
    logic             pop;
    logic             tail_release;
    logic             forced_release;

    assign req_vec = ~in_isempty;

    bz_rr_pick #(
        .NIN   (NIN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_vec),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // View of the FIFO currently addressed by sel
    always_comb begin
        sel_flit  = in_data[int'(sel)*FLIT_W +: FLIT_W];
        sel_empty = in_isempty[sel];
    end

    // A pop only exists while locked and the locked FIFO has a flit; the
    // header tail bit is ignored, and the length guard yields to a real tail
    always_comb begin
        pop            = (state == LOCK) && out_rdreq && !sel_empty;
        tail_release   = pop && (flit_cnt != '0) && is_tail(sel_flit);
        forced_release = pop && !tail_release && (flit_cnt == LAST_CNT);
    end

    // Deserializer-facing FIFO view and per-port pop strobes
    always_comb begin
        out_isempty = 1'b1;
        out_data    = '0;
        grant       = '0;
        in_rdreq    = '0;
        if (state == LOCK) begin
            out_isempty   = sel_empty;
            out_data      = sel_flit;
            grant[sel]    = 1'b1;
            in_rdreq[sel] = pop;
        end
    end

    // Arbitration FSM: pick a port in IDLE, hold it until the packet ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= IDX_W'(NIN - 1);
            sel      <= '0;
            flit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        sel      <= pick_idx;
                        flit_cnt <= '0;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (pop) begin
                        flit_cnt <= flit_cnt + CNT_W'(1);
                    end
                    if (tail_release || forced_release) begin
                        ptr   <= sel;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One-cycle error pulse in the cycle after a forced release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overlong <= 1'b0;
        end else begin
            err_overlong <= forced_release;
        end
    end

`ifdef BZ_RX_ARB_STATS_EN
    logic [15:0] pkt_cnt_q [NIN];
    logic [7:0]  overlong_cnt_q;

    // Per-port count of normally terminated packets, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NIN; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else if (tail_release && (pkt_cnt_q[sel] != 16'hFFFF)) begin
            pkt_cnt_q[sel] <= pkt_cnt_q[sel] + 16'd1;
        end
    end

    // Saturating count of forced releases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overlong_cnt_q <= '0;
        end else if (forced_release && (overlong_cnt_q != 8'hFF)) begin
            overlong_cnt_q <= overlong_cnt_q + 8'd1;
        end
    end

    // Flatten the per-port counters onto the output bus
    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < NIN; i++) begin
            pkt_count[i*16 +: 16] = pkt_cnt_q[i];
        end
    end

    assign overlong_count = overlong_cnt_q;
`endif

endmodule

// File: tb/tb_bz_rx_arbiter.sv
// Self-checking bench for bz_rx_arbiter. Per-port show-ahead FIFOs are
// modelled with queues; every expected deserializer pop is pushed to a
// scoreboard in the order the arbiter must deliver it and compared when the
// DUT actually pops. Priority cases come from a table of hand-derived orders.
module tb_bz_rx_arbiter;
    import bz_rx_arb_pkg::*;

    localparam int NIN       = 4;
    localparam int MAX_FLITS = 5;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NIN-1:0]        in_isempty;
    logic [NIN*FLIT_W-1:0] in_data;
    logic [NIN-1:0]        in_rdreq;
    logic                  out_isempty;
    logic [FLIT_W-1:0]     out_data;
    logic                  out_rdreq;
    logic [NIN-1:0]        grant;
    logic                  err_overlong;
`ifdef BZ_RX_ARB_STATS_EN
    logic [NIN*16-1:0]     pkt_count;
    logic [7:0]            overlong_count;
`endif

    bz_rx_arbiter #(
        .NIN       (NIN),
        .MAX_FLITS (MAX_FLITS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_isempty     (in_isempty),
        .in_data        (in_data),
        .in_rdreq       (in_rdreq),
        .out_isempty    (out_isempty),
        .out_data       (out_data),
        .out_rdreq      (out_rdreq),
        .grant          (grant),
        .err_overlong   (err_overlong)
`ifdef BZ_RX_ARB_STATS_EN
        ,
        .pkt_count      (pkt_count),
        .overlong_count (overlong_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int    port;
        flit_t flit;
        bit    last;
        bit    forced;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         count;
        logic [7:0] order;
    } vec_t;

    exp_t           exp_q [$];
    flit_t          fifo_q [NIN][$];
    vec_t           vecs [6];
    int             tests_run = 0;
    int             tests_failed = 0;
    bit             expect_idle = 1'b0;
    bit             expect_err = 1'b0;
    logic [NIN-1:0] s_grant;
    logic           s_empty;

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Present the head of every model FIFO to the DUT
    task automatic applyStimulus();
        for (int i = 0; i < NIN; i++) begin
            if (fifo_q[i].size() == 0) begin
                in_isempty[i] = 1'b1;
                in_data[i*FLIT_W +: FLIT_W] = '0;
            end else begin
                in_isempty[i] = 1'b0;
                in_data[i*FLIT_W +: FLIT_W] = fifo_q[i][0];
            end
        end
    endtask

    // Sampled mid-cycle: idle-gap and error-pulse checks, scoreboard pops
    task automatic checkOutput();
        bit   pop;
        bit   next_idle;
        bit   next_err;
        exp_t e;
        next_idle = 1'b0;
        next_err  = 1'b0;
        s_grant   = grant;
        s_empty   = out_isempty;
        pop       = out_rdreq && !out_isempty;
        if (expect_idle) begin
            check_value("idle_gap_grant", 32'(grant), 32'd0);
            check_value("idle_gap_empty", 32'(out_isempty), 32'd1);
        end
        check_value("err_overlong", 32'(err_overlong), 32'(expect_err));
        if (pop) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_pop: got flit 0x%0h grant 0x%0h, expected no pop", out_data, grant);
            end else begin
                e = exp_q.pop_front();
                check_value("pop_grant", 32'(grant), 32'(1) << e.port);
                check_value("pop_data", 32'(out_data), 32'(e.flit));
                check_value("pop_rdreq", 32'(in_rdreq), 32'(1) << e.port);
                next_idle = e.last;
                next_err  = e.forced;
            end
        end else begin
            check_value("rdreq_without_pop", 32'(in_rdreq), 32'd0);
        end
        for (int i = 0; i < NIN; i++) begin
            if (in_rdreq[i] && fifo_q[i].size() > 0) begin
                void'(fifo_q[i].pop_front());
            end
        end
        expect_idle = next_idle;
        expect_err  = next_err;
    endtask

    task automatic tick(input logic rd);
        out_rdreq = rd;
        applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        out_rdreq = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            fifo_q[i].delete();
        end
        exp_q.delete();
        expect_idle = 1'b0;
        expect_err  = 1'b0;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic flit_t pkt_flit(input int base, input int k, input int n);
        flit_t f;
        f = flit_t'(base + k);
        if (k == n - 1) begin
            f[TAIL_BIT] = 1'b1;
        end
        return f;
    endfunction

    task automatic load_pkt(input int port, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            fifo_q[port].push_back(pkt_flit(base, k, n));
        end
    endtask

    task automatic expect_pkt(input int port, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{port: port, flit: pkt_flit(base, k, n), last: (k == n - 1), forced: 1'b0});
        end
    endtask

    // Pop continuously until the scoreboard is drained, then one quiet cycle
    task automatic run_drain(input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            tick(1'b1);
            cyc++;
        end
        if (exp_q.size() > 0) begin
            check_value("drain_timeout_left", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        tick(1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Priority table: loads are simultaneous, ptr carries over records.
        vecs[0] = '{mask: 4'b0110, count: 2, order: 8'b00_00_10_01};
        vecs[1] = '{mask: 4'b1011, count: 3, order: 8'b00_01_00_11};
        vecs[2] = '{mask: 4'b1111, count: 4, order: 8'b01_00_11_10};
        vecs[3] = '{mask: 4'b0011, count: 2, order: 8'b00_00_01_00};
        vecs[4] = '{mask: 4'b0010, count: 1, order: 8'b00_00_00_01};
        vecs[5] = '{mask: 4'b1001, count: 2, order: 8'b00_00_00_11};

        out_rdreq = 1'b0;
        applyStimulus();

        // Reset state, observed while reset is held and just after release
        @(negedge clk);
        check_value("reset_empty", 32'(out_isempty), 32'd1);
        check_value("reset_grant", 32'(grant), 32'd0);
        check_value("reset_data", 32'(out_data), 32'd0);
        check_value("reset_rdreq", 32'(in_rdreq), 32'd0);
        check_value("reset_err", 32'(err_overlong), 32'd0);
        do_reset();
        tick(1'b1);
        check_value("post_reset_grant", 32'(s_grant), 32'd0);

        // Single port 2 packet, with arbitration latency checks
        do_reset();
        fifo_q[2].push_back(11'h000);
        fifo_q[2].push_back(11'h155);
        fifo_q[2].push_back(11'h2AA);
        fifo_q[2].push_back(11'h401);
        exp_q.push_back('{port: 2, flit: 11'h000, last: 1'b0, forced: 1'b0});
        exp_q.push_back('{port: 2, flit: 11'h155, last: 1'b0, forced: 1'b0});
        exp_q.push_back('{port: 2, flit: 11'h2AA, last: 1'b0, forced: 1'b0});
        exp_q.push_back('{port: 2, flit: 11'h401, last: 1'b1, forced: 1'b0});
        tick(1'b0);
        check_value("arb_cycle_empty", 32'(s_empty), 32'd1);
        check_value("arb_cycle_grant", 32'(s_grant), 32'd0);
        tick(1'b0);
        check_value("lock_cycle_empty", 32'(s_empty), 32'd0);
        check_value("lock_cycle_grant", 32'(s_grant), 32'b0100);
        run_drain(20);
        check_value("single_done_grant", 32'(s_grant), 32'd0);

        // Contention after reset: port 0 first, then port 1
        do_reset();
        load_pkt(0, 11'h100, 4);
        load_pkt(1, 11'h200, 4);
        expect_pkt(0, 11'h100, 4);
        expect_pkt(1, 11'h200, 4);
        run_drain(40);

        // Round robin with continuously refilled ports 0, 1, 3
        do_reset();
        load_pkt(0, 11'h010, 3);
        load_pkt(0, 11'h018, 3);
        load_pkt(1, 11'h020, 3);
        load_pkt(1, 11'h028, 3);
        load_pkt(3, 11'h030, 3);
        load_pkt(3, 11'h038, 3);
        expect_pkt(0, 11'h010, 3);
        expect_pkt(1, 11'h020, 3);
        expect_pkt(3, 11'h030, 3);
        expect_pkt(0, 11'h018, 3);
        expect_pkt(1, 11'h028, 3);
        expect_pkt(3, 11'h038, 3);
        run_drain(80);

        // Table-driven priority order
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < NIN; p++) begin
                if (vecs[r].mask[p]) begin
                    load_pkt(p, 'h300 + 16 * r + 4 * p, 2);
                end
            end
            for (int k = 0; k < vecs[r].count; k++) begin
                int p;
                p = int'(vecs[r].order[2*k +: 2]);
                expect_pkt(p, 'h300 + 16 * r + 4 * p, 2);
            end
            run_drain(40);
        end

        // Header tail bit ignored, then a 10-cycle stall with a rival waiting
        do_reset();
        fifo_q[1].push_back(11'h400);
        exp_q.push_back('{port: 1, flit: 11'h400, last: 1'b0, forced: 1'b0});
        begin
            int cyc;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 10) begin
                tick(1'b1);
                cyc++;
            end
        end
        load_pkt(0, 11'h070, 2);
        for (int c = 0; c < 10; c++) begin
            tick(1'b1);
            check_value("stall_grant", 32'(s_grant), 32'b0010);
            check_value("stall_empty", 32'(s_empty), 32'd1);
        end
        fifo_q[1].push_back(11'h001);
        fifo_q[1].push_back(11'h002);
        fifo_q[1].push_back(11'h403);
        exp_q.push_back('{port: 1, flit: 11'h001, last: 1'b0, forced: 1'b0});
        exp_q.push_back('{port: 1, flit: 11'h002, last: 1'b0, forced: 1'b0});
        exp_q.push_back('{port: 1, flit: 11'h403, last: 1'b1, forced: 1'b0});
        expect_pkt(0, 11'h070, 2);
        run_drain(40);

        // Overlong: five tail-less flits force a release, then port 3 runs
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fifo_q[2].push_back(flit_t'(11'h010 + k));
            exp_q.push_back('{port: 2, flit: flit_t'(11'h010 + k), last: (k == 4), forced: (k == 4)});
        end
        load_pkt(3, 11'h030, 2);
        expect_pkt(3, 11'h030, 2);
        run_drain(40);

        // Reset in the middle of a packet after two pops
        do_reset();
        load_pkt(0, 11'h050, 4);
        load_pkt(1, 11'h060, 2);
        exp_q.push_back('{port: 0, flit: 11'h050, last: 1'b0, forced: 1'b0});
        exp_q.push_back('{port: 0, flit: 11'h051, last: 1'b0, forced: 1'b0});
        begin
            int cyc;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 20) begin
                tick(1'b1);
                cyc++;
            end
        end
        check_value("midreset_pops_left", 32'(exp_q.size()), 32'd0);
        reset     = 1'b1;
        out_rdreq = 1'b0;
        #1;
        check_value("midreset_grant", 32'(grant), 32'd0);
        check_value("midreset_empty", 32'(out_isempty), 32'd1);
        check_value("midreset_rdreq", 32'(in_rdreq), 32'd0);
        exp_q.delete();
        expect_idle = 1'b0;
        expect_err  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back('{port: 0, flit: 11'h052, last: 1'b0, forced: 1'b0});
        exp_q.push_back('{port: 0, flit: 11'h453, last: 1'b1, forced: 1'b0});
        expect_pkt(1, 11'h060, 2);
        run_drain(40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
